axi_read_xbar: RTL

- Parametrised AXI4 read-path crossbar: NUM_M read masters to NUM_S read slaves.
- Round-robin arbitration among masters; address decode selects the slave.
- One outstanding transaction at a time across the whole fabric.
- Built-in default slave answers unmapped addresses with DECERR; slave-side IDs carry the master index. Replaces fixed 2x2 read arbiter/channel logic in the bus fabric.

---
 rtl/axi_read_xbar.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_xbar.sv
// AXI4 read-path crossbar: NUM_M masters to NUM_S slaves, round-robin grant,
// one transaction in flight, built-in DECERR responder for unmapped addresses.
//   state | meaning
//   IDLE  | arbitrate among ARVALID_M, latch grant and decoded slave
//   ADDR  | forward granted AR to the selected slave until handshake
//   DATA  | route R beats from the selected slave to the granted master
//   DERR  | accept AR locally, then return ARLEN+1 DECERR beats
module axi_read_xbar #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SEL_LSB   = 16,
  localparam int MB  = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SB  = ($clog2(NUM_S + 1) > 1) ? $clog2(NUM_S + 1) : 1,
  localparam int IDS = ID_BITS + MB
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_M*ID_BITS-1:0]      ARID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]    ARADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]     ARLEN_M,
  input  logic [NUM_M*3-1:0]            ARSIZE_M,
  input  logic [NUM_M*2-1:0]            ARBURST_M,
  input  logic [NUM_M-1:0]              ARVALID_M,
  output logic [NUM_M-1:0]              ARREADY_M,
  output logic [NUM_M*ID_BITS-1:0]      RID_M,
  output logic [NUM_M*DATA_BITS-1:0]    RDATA_M,
  output logic [NUM_M*2-1:0]            RRESP_M,
  output logic [NUM_M-1:0]              RLAST_M,
  output logic [NUM_M-1:0]              RVALID_M,
  input  logic [NUM_M-1:0]              RREADY_M,
  output logic [NUM_S*IDS-1:0]          ARID_S,
  output logic [NUM_S*ADDR_BITS-1:0]    ARADDR_S,
  output logic [NUM_S*LEN_BITS-1:0]     ARLEN_S,
  output logic [NUM_S*3-1:0]            ARSIZE_S,
  output logic [NUM_S*2-1:0]            ARBURST_S,
  output logic [NUM_S-1:0]              ARVALID_S,
  input  logic [NUM_S-1:0]              ARREADY_S,
  input  logic [NUM_S*IDS-1:0]          RID_S,
  input  logic [NUM_S*DATA_BITS-1:0]    RDATA_S,
  input  logic [NUM_S*2-1:0]            RRESP_S,
  input  logic [NUM_S-1:0]              RLAST_S,
  input  logic [NUM_S-1:0]              RVALID_S,
  output logic [NUM_S-1:0]              RREADY_S
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DERR} state_t;

  state_t              state;
  logic [MB-1:0]       grant;
  logic [MB-1:0]       rr_ptr;
  logic [SB-1:0]       sel;
  logic [LEN_BITS-1:0] beat_cnt;
  logic [LEN_BITS-1:0] derr_len;
  logic [ID_BITS-1:0]  derr_id;
  logic                derr_acc;

  logic                any_req;
  logic [MB-1:0]       pick;
  logic [MB:0]         pick_sum;
  logic [2*NUM_M-1:0]  req_rot;
  logic [MB-1:0]       nxt_ptr;

  // Rotate requests so bit 0 is the rr pointer; lowest set bit is the winner.
  always_comb begin
    req_rot  = {ARVALID_M, ARVALID_M} >> rr_ptr;
    any_req  = |ARVALID_M;
    pick_sum = '0;
    for (int i = NUM_M - 1; i >= 0; i--)
      if (req_rot[i]) pick_sum = {1'b0, rr_ptr} + (MB+1)'(i);
    if (pick_sum >= (MB+1)'(NUM_M)) pick_sum = pick_sum - (MB+1)'(NUM_M);
    pick = pick_sum[MB-1:0];
  end

  assign nxt_ptr = (grant == MB'(NUM_M - 1)) ? '0 : grant + 1'b1;

  logic [SB-1:0]       p_sel;
  logic [ID_BITS-1:0]  p_id;
  logic [LEN_BITS-1:0] p_len;

  always_comb begin
    p_sel = '0;
    p_id  = '0;
    p_len = '0;
    for (int i = 0; i < NUM_M; i++)
      if (pick == MB'(i)) begin
        p_sel = ARADDR_M[i*ADDR_BITS+SEL_LSB +: SB];
        p_id  = ARID_M[i*ID_BITS +: ID_BITS];
        p_len = ARLEN_M[i*LEN_BITS +: LEN_BITS];
      end
  end

  logic [ID_BITS-1:0]   g_id;
  logic [ADDR_BITS-1:0] g_addr;
  logic [LEN_BITS-1:0]  g_len;
  logic [2:0]           g_size;
  logic [1:0]           g_burst;
  logic                 g_valid;
  logic                 g_rready;

  always_comb begin
    g_id     = '0;
    g_addr   = '0;
    g_len    = '0;
    g_size   = '0;
    g_burst  = '0;
    g_valid  = 1'b0;
    g_rready = 1'b0;
    for (int i = 0; i < NUM_M; i++)
      if (grant == MB'(i)) begin
        g_id     = ARID_M[i*ID_BITS +: ID_BITS];
        g_addr   = ARADDR_M[i*ADDR_BITS +: ADDR_BITS];
        g_len    = ARLEN_M[i*LEN_BITS +: LEN_BITS];
        g_size   = ARSIZE_M[i*3 +: 3];
        g_burst  = ARBURST_M[i*2 +: 2];
        g_valid  = ARVALID_M[i];
        g_rready = RREADY_M[i];
      end
  end

  logic                 s_arready;
  logic                 s_rvalid;
  logic                 s_rlast;
  logic [ID_BITS-1:0]   s_rid;
  logic [DATA_BITS-1:0] s_rdata;
  logic [1:0]           s_rresp;
  // Master-index bits of RID_S are redundant with the latched grant.
  logic [NUM_S*MB-1:0]  rid_hi_unused;

  always_comb begin
    s_arready     = 1'b0;
    s_rvalid      = 1'b0;
    s_rlast       = 1'b0;
    s_rid         = '0;
    s_rdata       = '0;
    s_rresp       = '0;
    rid_hi_unused = '0;
    for (int s = 0; s < NUM_S; s++) begin
      rid_hi_unused[s*MB +: MB] = RID_S[s*IDS+ID_BITS +: MB];
      if (sel == SB'(s)) begin
        s_arready = ARREADY_S[s];
        s_rvalid  = RVALID_S[s];
        s_rlast   = RLAST_S[s];
        s_rid     = RID_S[s*IDS +: ID_BITS];
        s_rdata   = RDATA_S[s*DATA_BITS +: DATA_BITS];
        s_rresp   = RRESP_S[s*2 +: 2];
      end
    end
  end

  always_comb begin
    ARREADY_M = '0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = '0;
    RLAST_M   = '0;
    RVALID_M  = '0;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    ARVALID_S = '0;
    RREADY_S  = '0;
    case (state)
      ADDR: begin
        for (int s = 0; s < NUM_S; s++)
          if (sel == SB'(s)) begin
            ARVALID_S[s]                       = g_valid;
            ARID_S[s*IDS +: IDS]               = {grant, g_id};
            ARADDR_S[s*ADDR_BITS +: ADDR_BITS] = g_addr;
            ARLEN_S[s*LEN_BITS +: LEN_BITS]    = g_len;
            ARSIZE_S[s*3 +: 3]                 = g_size;
            ARBURST_S[s*2 +: 2]                = g_burst;
          end
        for (int i = 0; i < NUM_M; i++)
          if (grant == MB'(i)) ARREADY_M[i] = s_arready;
      end
      DATA: begin
        for (int i = 0; i < NUM_M; i++)
          if (grant == MB'(i)) begin
            RVALID_M[i]                       = s_rvalid;
            RLAST_M[i]                        = s_rlast;
            RID_M[i*ID_BITS +: ID_BITS]       = s_rid;
            RDATA_M[i*DATA_BITS +: DATA_BITS] = s_rdata;
            RRESP_M[i*2 +: 2]                 = s_rresp;
          end
        for (int s = 0; s < NUM_S; s++)
          if (sel == SB'(s)) RREADY_S[s] = g_rready;
      end
      DERR: begin
        for (int i = 0; i < NUM_M; i++)
          if (grant == MB'(i)) begin
            if (!derr_acc) begin
              ARREADY_M[i] = g_valid;
            end else begin
              RVALID_M[i]                 = 1'b1;
              RLAST_M[i]                  = (beat_cnt == derr_len);
              RID_M[i*ID_BITS +: ID_BITS] = derr_id;
              RRESP_M[i*2 +: 2]           = 2'b11;
            end
          end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      sel      <= '0;
      beat_cnt <= '0;
      derr_len <= '0;
      derr_id  <= '0;
      derr_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= pick;
            sel      <= p_sel;
            derr_id  <= p_id;
            beat_cnt <= '0;
            derr_acc <= 1'b0;
            if (p_sel >= SB'(NUM_S)) begin
              derr_len <= p_len;
              state    <= DERR;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: if (g_valid && s_arready) state <= DATA;
        DATA: begin
          if (s_rvalid && g_rready && s_rlast) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        DERR: begin
          if (!derr_acc) begin
            if (g_valid) derr_acc <= 1'b1;
          end else if (g_rready) begin
            if (beat_cnt == derr_len) begin
              state    <= IDLE;
              rr_ptr   <= nxt_ptr;
              beat_cnt <= '0;
              derr_acc <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
